// File: rtl/yif_fetch_queue.sv
// ---------------------------------------------------------------------------
// yif_fetch_queue
//   Instruction prefetch queue between fetch (yIF/yPC) and decode (yID).
//   Holds up to DEPTH {PC, instruction} pairs so fetch can keep running while
//   decode stalls. A redirect (flush) discards every entry. When the queue
//   is empty, decode sees a NOP and a zero PC.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      redirect: drop all entries at this edge
//   in_valid   fetch offers {in_pc, in_ins}
//   in_ready   queue has room (depends on state only)
//   in_pc      PC of offered instruction
//   in_ins     offered instruction word
//   out_valid  head entry valid
//   out_ready  decode consumes head at this edge
//   out_pc     PC of head entry (0 when empty)
//   out_ins    head instruction (NOP when empty)
//   count      number of entries currently held
// ---------------------------------------------------------------------------
module yif_fetch_queue #(
  parameter int unsigned     DEPTH = 4,
  parameter int unsigned     XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_ins,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_ins,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Storage is never reset: nothing in it is visible while count is zero.
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // Handshake status comes purely from the occupancy register, so in_ready
  // never combinationally depends on decode's out_ready.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next-state for pointers and occupancy. A redirect zeroes everything and
  // swallows any push/pop offered in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leave occupancy unchanged.
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; gated by rst_n only so reset cleanly dominates a push.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem[wr_ptr_q]  <= in_pc;
      ins_mem[wr_ptr_q] <= in_ins;
    end
  end

  // Show-ahead head: decode sees the oldest entry directly, no read latency.
  assign out_pc  = out_valid ? pc_mem[rd_ptr_q]  : '0;
  assign out_ins = out_valid ? ins_mem[rd_ptr_q] : NOP;
  assign count   = count_q;

endmodule

// File: tb/tb_yif_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_yif_fetch_queue
//   Directed stimulus for the prefetch queue. A reference queue of expected
//   {PC, instruction} entries is updated at every clock edge from the offered
//   stimulus; a monitor on the falling edge compares the DUT head and status
//   against it. Directed checks confirm the hand-computed scenario values.
// ---------------------------------------------------------------------------
module tb_yif_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic [2:0]  count;

  yif_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .NOP(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_ins    (in_ins),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_ins   (out_ins),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];       // expected queue contents
  logic [31:0] popped[$];   // PCs the reference saw consumed
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  bit          do_pop;
  bit          do_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h @%0t", name, act, exp, $time);
    end
  endtask

  // Instruction word derived from PC so each entry is distinguishable.
  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  // Reference queue update at each edge, from the offered stimulus.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && out_ready;
      do_push = in_valid && (sb.size() != DEPTH);
      if (do_pop) begin
        popped.push_back(sb[0].pc);
        void'(sb.pop_front());
      end
      if (do_push) begin
        sb.push_back('{pc: in_pc, ins: in_ins});
      end
    end
  end

  // Monitor: compare what the DUT presents against the reference head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0) begin
        chk("mon_valid", {31'd0, out_valid}, 32'd1);
        chk("mon_pc",    out_pc,  sb[0].pc);
        chk("mon_ins",   out_ins, sb[0].ins);
      end else begin
        chk("mon_valid", {31'd0, out_valid}, 32'd0);
        chk("mon_pc",    out_pc,  32'd0);
        chk("mon_ins",   out_ins, NOP);
      end
      chk("mon_count", {29'd0, count}, 32'(sb.size()));
      chk("mon_ready", {31'd0, in_ready}, {31'd0, sb.size() != DEPTH});
      $display("cyc t=%0t cnt=%0d v=%0b pc=%08h ins=%08h rdy=%0b",
               $time, count, out_valid, out_pc, out_ins, in_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ins   = ins_of(pc);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_ins = '0;

    // 1. Reset with a pending offer.
    offer(32'h1000);
    step();
    mon_en = 1'b1;
    step();
    chk("t1_count", {29'd0, count}, 32'd0);
    chk("t1_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_ins",   out_ins, 32'h00000013);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();

    // 2. Fill with decode stalled; 5th offer must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h28 + 32'(4 * i));
      step();
    end
    chk("t2_count", {29'd0, count}, 32'd4);
    chk("t2_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_pc",    out_pc,  32'h28);
    chk("t2_ins",   out_ins, 32'h5A5A_0028);
    offer(32'h38);
    step();
    chk("t2_count5", {29'd0, count}, 32'd4);
    chk("t2_pc5",    out_pc, 32'h28);
    in_valid = 1'b0;

    // 3. Drain in order.
    popped.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_pc", out_pc, 32'h28 + 32'(4 * i));
      step();
    end
    chk("t3_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_ins",   out_ins, 32'h00000013);
    chk("t3_npop",  32'(popped.size()), 32'd4);

    // 4. Streaming: push and pop every cycle, pointers wrap twice.
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      offer(32'h40 + 32'(4 * i));
      step();
      chk("t4_count", {29'd0, count}, 32'd1);
      chk("t4_pc",    out_pc, 32'h40 + 32'(4 * i));
    end
    in_valid = 1'b0;
    step();
    chk("t4_empty", {29'd0, count}, 32'd0);
    chk("t4_npop",  32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size() && i < 10; i++) begin
      chk("t4_order", popped[i], 32'h40 + 32'(4 * i));
    end

    // 5. Flush at count=3 alongside a push and a pop.
    popped.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h50 + 32'(4 * i));
      step();
    end
    chk("t5_count3", {29'd0, count}, 32'd3);
    offer(32'h60);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("t5_count", {29'd0, count}, 32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_ins",   out_ins, 32'h00000013);
    chk("t5_npop",  32'(popped.size()), 32'd0);
    offer(32'h80);
    step();
    in_valid = 1'b0;
    chk("t5_pc80",  out_pc, 32'h80);
    chk("t5_cnt1",  {29'd0, count}, 32'd1);

    // 6. Reset together with flush while count=2.
    offer(32'h84);
    step();
    chk("t6_count2", {29'd0, count}, 32'd2);
    rst_n = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    offer(32'h88);
    step();
    step();
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_ins",   out_ins, 32'h00000013);
    chk("t6_pc",    out_pc,  32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
